// File: rtl/accel_bcd_formatter.sv
// Purpose: scale N signed axis samples by 1/SCALE and convert them to BCD digits, sign and saturation flags for seven-segment display.
// Latency: update pulses CHANNELS*(2*DATA_W+2)+1 cycles after the capture edge; outputs then hold until the next update.
// Backpressure: none; a refresh tick that arrives while busy or frozen is dropped, and data_valid only refreshes the shadow registers.
module accel_bcd_formatter #(
   parameter int DATA_W      = 16,
   parameter int CHANNELS    = 3,
   parameter int DIGITS      = 2,
   parameter int SCALE       = 10,
   parameter int REFRESH_DIV = 50000000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [CHANNELS*DATA_W-1:0]   data_in,
   input  logic                         data_valid,
   input  logic                         freeze,
   output logic [CHANNELS*DIGITS*4-1:0] digits_out,
   output logic [CHANNELS-1:0]          neg_out,
   output logic [CHANNELS-1:0]          sat_out,
   output logic                         update,
   output logic                         busy
);

   localparam int BCD_W = DIGITS*4 + 4;
   localparam int NIBS  = BCD_W / 4;
   localparam int RC_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BC_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int LIMIT = 10**DIGITS;

   localparam logic [DATA_W:0]       SCALE_V = (DATA_W+1)'(SCALE);
   localparam logic [DIGITS*4-1:0]   ALL9    = {DIGITS{4'h9}};

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ABS   = 3'd1;
   localparam logic [2:0] S_DIV   = 3'd2;
   localparam logic [2:0] S_BCD   = 3'd3;
   localparam logic [2:0] S_STORE = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]                   state;
   logic [CHANNELS*DATA_W-1:0]   shadow;
   logic [CHANNELS*DATA_W-1:0]   snap;
   logic [RC_W-1:0]              ref_cnt;
   logic                         tick;
   logic [CH_W-1:0]              ch;
   logic [BC_W-1:0]              bit_cnt;
   logic                         last_bit;
   // dq holds the magnitude, becomes the quotient during DIV, and is rotated
   // through BCD so it is back to the quotient when STORE checks saturation.
   logic [DATA_W-1:0]            dq;
   logic [DATA_W-1:0]            rem;
   logic [DATA_W:0]              trial;
   logic [BCD_W-1:0]             bcd;
   logic [BCD_W-1:0]             adj;
   logic [DATA_W-1:0]            sample;
   logic [DATA_W-1:0]            mag;
   logic                         sat_now;
   logic [CHANNELS*DIGITS*4-1:0] stage_digits;
   logic [CHANNELS-1:0]          stage_neg;
   logic [CHANNELS-1:0]          stage_sat;

   assign tick     = (ref_cnt == RC_W'(REFRESH_DIV - 1));
   assign last_bit = (bit_cnt == BC_W'(DATA_W - 1));
   assign sample   = snap[ch*DATA_W +: DATA_W];
   // Two's-complement negate; the most negative value comes out as 2^(DATA_W-1) unsigned.
   assign mag      = sample[DATA_W-1] ? -sample : sample;
   assign trial    = {rem, dq[DATA_W-1]};
   assign sat_now  = 64'(dq) >= 64'(LIMIT);
   assign busy     = (state != S_IDLE);

   // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
   always_comb begin
      adj = bcd;
      for (int i = 0; i < NIBS; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
   end

   // Shadow copy of the most recent valid sample set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             shadow <= '0;
      else if (data_valid) shadow <= data_in;
   end

   // Free-running refresh counter; its terminal count is the capture tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       ref_cnt <= '0;
      else if (tick) ref_cnt <= '0;
      else           ref_cnt <= ref_cnt + 1'b1;
   end

   // Per-channel abs / divide / BCD sequencer with staged, atomically published results.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         snap         <= '0;
         ch           <= '0;
         bit_cnt      <= '0;
         dq           <= '0;
         rem          <= '0;
         bcd          <= '0;
         stage_digits <= '0;
         stage_neg    <= '0;
         stage_sat    <= '0;
         digits_out   <= '0;
         neg_out      <= '0;
         sat_out      <= '0;
         update       <= 1'b0;
      end else begin
         update <= 1'b0;
         case (state)
            S_IDLE: begin
               if (tick && !freeze) begin
                  snap  <= data_valid ? data_in : shadow;
                  ch    <= '0;
                  state <= S_ABS;
               end
            end
            S_ABS: begin
               stage_neg[ch] <= sample[DATA_W-1];
               dq            <= mag;
               rem           <= '0;
               bit_cnt       <= '0;
               state         <= S_DIV;
            end
            S_DIV: begin
               if (trial >= SCALE_V) begin
                  rem <= DATA_W'(trial - SCALE_V);
                  dq  <= {dq[DATA_W-2:0], 1'b1};
               end else begin
                  rem <= trial[DATA_W-1:0];
                  dq  <= {dq[DATA_W-2:0], 1'b0};
               end
               bit_cnt <= bit_cnt + 1'b1;
               if (last_bit) begin
                  bit_cnt <= '0;
                  bcd     <= '0;
                  state   <= S_BCD;
               end
            end
            S_BCD: begin
               bcd     <= (adj << 1) | BCD_W'(dq[DATA_W-1]);
               dq      <= {dq[DATA_W-2:0], dq[DATA_W-1]};
               bit_cnt <= bit_cnt + 1'b1;
               if (last_bit) begin
                  bit_cnt <= '0;
                  state   <= S_STORE;
               end
            end
            S_STORE: begin
               stage_digits[ch*DIGITS*4 +: DIGITS*4] <= sat_now ? ALL9 : bcd[DIGITS*4-1:0];
               stage_sat[ch] <= sat_now;
               if (ch == CH_W'(CHANNELS - 1)) begin
                  state <= S_DONE;
               end else begin
                  ch    <= ch + 1'b1;
                  state <= S_ABS;
               end
            end
            S_DONE: begin
               digits_out <= stage_digits;
               neg_out    <= stage_neg;
               sat_out    <= stage_sat;
               update     <= 1'b1;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_accel_bcd_formatter.sv
// Directed bench for accel_bcd_formatter: three instances cover the default
// 3-axis path (refresh 8), a fast refresh (4) and a 1-channel 4-digit variant.
module tb_accel_bcd_formatter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   int checks = 0;
   int errors = 0;

   // 3-axis instance, refresh every 8 cycles
   logic        rst_a, dv_a, frz_a, upd_a, busy_a;
   logic [47:0] din_a;
   logic [23:0] dig_a;
   logic [2:0]  neg_a, sat_a;
   // 3-axis instance, refresh every 4 cycles
   logic        rst_b, dv_b, frz_b, upd_b, busy_b;
   logic [47:0] din_b;
   logic [23:0] dig_b;
   logic [2:0]  neg_b, sat_b;
   // 1-axis, 4 digits, no scaling
   logic        rst_c, dv_c, frz_c, upd_c, busy_c;
   logic [15:0] din_c;
   logic [15:0] dig_c;
   logic [0:0]  neg_c, sat_c;

   accel_bcd_formatter #(.DATA_W(16), .CHANNELS(3), .DIGITS(2), .SCALE(10), .REFRESH_DIV(8)) u_dut_a (
      .clk(clk), .rst(rst_a), .data_in(din_a), .data_valid(dv_a), .freeze(frz_a),
      .digits_out(dig_a), .neg_out(neg_a), .sat_out(sat_a), .update(upd_a), .busy(busy_a));

   accel_bcd_formatter #(.DATA_W(16), .CHANNELS(3), .DIGITS(2), .SCALE(10), .REFRESH_DIV(4)) u_dut_b (
      .clk(clk), .rst(rst_b), .data_in(din_b), .data_valid(dv_b), .freeze(frz_b),
      .digits_out(dig_b), .neg_out(neg_b), .sat_out(sat_b), .update(upd_b), .busy(busy_b));

   accel_bcd_formatter #(.DATA_W(16), .CHANNELS(1), .DIGITS(4), .SCALE(1), .REFRESH_DIV(8)) u_dut_c (
      .clk(clk), .rst(rst_c), .data_in(din_c), .data_valid(dv_c), .freeze(frz_c),
      .digits_out(dig_c), .neg_out(neg_c), .sat_out(sat_c), .update(upd_c), .busy(busy_c));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Waits (bounded) for an update pulse on the selected instance; returns its edge number or -1.
   task automatic wait_upd(input string tag, input int which, input int budget, output int at);
      logic u;
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         case (which)
            0:       u = upd_a;
            1:       u = upd_b;
            default: u = upd_c;
         endcase
         if (u) begin
            at = edge_cnt;
            break;
         end
      end
      chk({tag, "_seen"}, 64'(at >= 0), 64'd1);
   endtask

   // Called #1 after an edge: release reset and present one data_valid strobe.
   task automatic start_a(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z, output int e0);
      rst_a = 1'b0;
      din_a = {z, y, x};
      dv_a  = 1'b1;
      e0    = edge_cnt;
      @(posedge clk);
      #1;
      dv_a  = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int e0, at, prev, n, seen;
      int t[8];
      logic any_upd, any_busy;

      rst_a = 1'b1; dv_a = 1'b0; frz_a = 1'b0; din_a = '0;
      rst_b = 1'b1; dv_b = 1'b0; frz_b = 1'b0; din_b = '0;
      rst_c = 1'b1; dv_c = 1'b0; frz_c = 1'b0; din_c = '0;
      repeat (3) @(posedge clk);
      #1;

      // reset state
      chk("rst_digits", 64'(dig_a), 64'h0);
      chk("rst_neg",    64'(neg_a), 64'h0);
      chk("rst_sat",    64'(sat_a), 64'h0);
      chk("rst_update", 64'(upd_a), 64'h0);
      chk("rst_busy",   64'(busy_a), 64'h0);

      // Test 1: X=123, Y=-57, Z=0
      start_a(16'd123, 16'hFFC7, 16'd0, e0);
      repeat (6) @(posedge clk);
      #1;
      chk("t1_busy_pre", 64'(busy_a), 64'h0);
      @(posedge clk);
      #1;
      chk("t1_busy_cap", 64'(busy_a), 64'h1);
      wait_upd("t1", 0, 200, at);
      chk("t1_latency", 64'(at - e0 - 8), 64'd103);
      chk("t1_digits", 64'(dig_a), 64'h000512);
      chk("t1_neg",    64'(neg_a), 64'h2);
      chk("t1_sat",    64'(sat_a), 64'h0);
      prev = at;

      // Test 2: X=32767, Y=-32768, Z=990; strobe lands on the tick edge (bypass)
      din_a = {16'd990, 16'h8000, 16'd32767};
      dv_a  = 1'b1;
      @(posedge clk);
      #1;
      dv_a  = 1'b0;
      chk("t1_pulse_len", 64'(upd_a), 64'h0);
      chk("t2_bypass_busy", 64'(busy_a), 64'h1);
      wait_upd("t2", 0, 200, at);
      chk("t2_spacing", 64'(at - prev), 64'd104);
      chk("t2_digits", 64'(dig_a), 64'h999999);
      chk("t2_neg",    64'(neg_a), 64'h2);
      chk("t2_sat",    64'(sat_a), 64'h3);

      // Test 3: freeze holds the display while new data arrives
      frz_a = 1'b1;
      din_a = {16'd100, 16'hFFF8, 16'd45};
      dv_a  = 1'b1;
      any_upd = 1'b0;
      any_busy = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         dv_a = 1'b0;
         any_upd  = any_upd | upd_a;
         any_busy = any_busy | busy_a;
      end
      chk("t3_no_update", 64'(any_upd), 64'h0);
      chk("t3_no_busy",   64'(any_busy), 64'h0);
      chk("t3_hold_dig",  64'(dig_a), 64'h999999);
      chk("t3_hold_sat",  64'(sat_a), 64'h3);
      frz_a = 1'b0;
      wait_upd("t3", 0, 200, at);
      chk("t3_digits", 64'(dig_a), 64'h100004);
      chk("t3_neg",    64'(neg_a), 64'h2);
      chk("t3_sat",    64'(sat_a), 64'h0);

      // Test 5: reset 50 cycles into a conversion
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (busy_a) begin
            seen = 1;
            break;
         end
      end
      chk("t5_started", 64'(seen), 64'd1);
      repeat (50) @(posedge clk);
      #1;
      rst_a = 1'b1;
      #1;
      chk("t5_rst_digits", 64'(dig_a), 64'h0);
      chk("t5_rst_neg",    64'(neg_a), 64'h0);
      chk("t5_rst_sat",    64'(sat_a), 64'h0);
      chk("t5_rst_update", 64'(upd_a), 64'h0);
      chk("t5_rst_busy",   64'(busy_a), 64'h0);
      @(posedge clk);
      #1;
      start_a(16'hFC19, 16'd500, 16'hFFF6, e0);
      wait_upd("t5", 0, 200, at);
      chk("t5_latency", 64'(at - e0), 64'd111);
      chk("t5_digits", 64'(dig_a), 64'h015099);
      chk("t5_neg",    64'(neg_a), 64'h5);
      chk("t5_sat",    64'(sat_a), 64'h0);

      // Test 4: refresh every 4 cycles, ticks during a conversion are dropped
      rst_b = 1'b0;
      din_b = {16'd10000, 16'd7, 16'hFFFF};
      dv_b  = 1'b1;
      e0    = edge_cnt;
      n     = 0;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk);
         #1;
         dv_b = 1'b0;
         if (upd_b) begin
            if (n < 8) t[n] = edge_cnt - e0;
            n++;
         end
      end
      chk("t4_count", 64'(n), 64'd4);
      chk("t4_first", 64'(t[0]), 64'd107);
      for (int i = 1; i < 4 && i < n; i++) chk("t4_spacing", 64'(t[i] - t[i-1]), 64'd104);
      chk("t4_digits", 64'(dig_b), 64'h990000);
      chk("t4_neg",    64'(neg_b), 64'h1);
      chk("t4_sat",    64'(sat_b), 64'h4);

      // Test 6: one channel, four digits, SCALE=1
      rst_c = 1'b0;
      din_c = 16'd9876;
      dv_c  = 1'b1;
      e0    = edge_cnt;
      @(posedge clk);
      #1;
      dv_c  = 1'b0;
      wait_upd("t6a", 2, 100, at);
      chk("t6_latency", 64'(at - e0 - 8), 64'd35);
      chk("t6a_digits", 64'(dig_c), 64'h9876);
      chk("t6a_sat",    64'(sat_c), 64'h0);
      chk("t6a_neg",    64'(neg_c), 64'h0);

      din_c = 16'd10000;
      dv_c  = 1'b1;
      @(posedge clk);
      #1;
      dv_c  = 1'b0;
      wait_upd("t6b", 2, 100, at);
      chk("t6b_digits", 64'(dig_c), 64'h9999);
      chk("t6b_sat",    64'(sat_c), 64'h1);

      din_c = 16'h8000;
      dv_c  = 1'b1;
      @(posedge clk);
      #1;
      dv_c  = 1'b0;
      wait_upd("t6c", 2, 100, at);
      chk("t6c_digits", 64'(dig_c), 64'h9999);
      chk("t6c_sat",    64'(sat_c), 64'h1);
      chk("t6c_neg",    64'(neg_c), 64'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/accel_bcd_formatter.md
Name: accel_bcd_formatter

Overview:
- Parametrised successor to the accelerometer display path: N signed axis channels, scaled and converted to BCD digits for seven-segment drivers.
- Generalises channel count, data width, digit count, scale divisor and refresh rate.
- Adds behaviours the fixed path lacks: sign flag, saturation, freeze mode, atomic double-buffered outputs and an update handshake.
- Sequential divide and BCD conversion replace the combinational dividers.
- Sits between spi_control (data_x/y/z, data_update) and the seg7 instances.

Parameters:
- DATA_W, 16, signed sample width per channel.
- CHANNELS, 3, number of axes.
- DIGITS, 2, BCD digits per channel; legal range 1..4.
- SCALE, 10, unsigned divisor applied to |sample|; must be >=1.
- REFRESH_DIV, 50000000, clk cycles between refresh captures; must be >=2.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-high reset.
- data_in, in, CHANNELS*DATA_W, packed signed samples; channel 0 is in the LSBs.
- data_valid, in, 1, one-cycle strobe; data_in is valid in that cycle.
- freeze, in, 1, high = suppress new captures and hold the displayed values.
- digits_out, out, CHANNELS*DIGITS*4, packed BCD; channel c digit d is at bits [(c*DIGITS+d)*4 +: 4]; d=0 is the ones digit.
- neg_out, out, CHANNELS, sign of each displayed sample.
- sat_out, out, CHANNELS, 1 = value clipped to all-9s.
- update, out, 1, one-cycle pulse when the display outputs change.
- busy, out, 1, high while a conversion is in progress.

Behaviour:
- Reset (async, immediate): digits_out=0, neg_out=0, sat_out=0, update=0, busy=0, shadow regs=0, refresh counter=0, FSM=IDLE.
- Reset mid-conversion aborts the conversion with no update pulse.
- Shadow registers: on data_valid, shadow <= data_in (all channels).
- Refresh counter: counts 0..REFRESH_DIV-1 and wraps. The terminal count gives a one-cycle tick.
- Capture condition: tick && !freeze && FSM==IDLE.
  - On capture, the working snapshot <= shadow. If data_valid is in the same cycle, data_in is used instead (bypass).
  - A tick while busy or frozen is dropped, not queued. The counter never stops.
- FSM states and transitions:
  - IDLE -> ABS on capture; channel index c=0; busy=1 from the next cycle.
  - ABS (1 cycle): neg[c]=sample[DATA_W-1]; mag = neg ? -sample : sample, treated as DATA_W-bit unsigned. The most negative value maps to 2^(DATA_W-1).
  - DIV (DATA_W cycles): restoring division mag/SCALE, one quotient bit per cycle, MSB first; the remainder is discarded (truncation).
  - BCD (DATA_W cycles): double-dabble of the quotient into a DIGITS*4 + 4 bit BCD register. Add-3 correction is applied to any digit >=5 before each shift.
  - STORE (1 cycle):
    - If quotient >= 10^DIGITS: stage all digits = 9, sat[c]=1.
    - Else: stage the BCD digits, sat[c]=0.
    - If c<CHANNELS-1 then c++ and go to ABS, else go to DONE.
  - DONE (1 cycle): copy the staged digits/neg/sat of all channels to the outputs in a single edge; update=1; busy=0 next cycle; -> IDLE.
- Latency: the capture edge is T. update is high in cycle T + CHANNELS*(2*DATA_W+2) + 1 (defaults: T+103).
- Outputs are stable between update pulses; no partial channel update is ever visible.
- Zero input: digits=0, neg=0.
- Negative input whose magnitude truncates to 0 (e.g. -5, SCALE=10): digits=0, neg=1. neg_out reflects the raw sign.
- A freeze asserted mid-conversion does not abort the conversion; it completes and updates once.

Test Plan:
1. REFRESH_DIV=8, defaults otherwise; data_in X=123, Y=-57, Z=0 with data_valid; release rst.
   - update 103 cycles after the first tick.
   - digits X=12, Y=05, Z=00; neg_out=3'b010; sat_out=0.
2. X=32767, Y=-32768, Z=990:
   - X=99, sat=1; Y=99, sat=1, neg=1; Z=99, sat=0.
3. Assert freeze before a tick, change data_in:
   - no update pulse, outputs unchanged, busy stays 0.
   - Deassert freeze: the next tick converts the new values.
4. REFRESH_DIV=4, so ticks arrive while busy:
   - exactly one update per completed conversion; intermediate ticks are dropped.
   - update spacing is a multiple of 4 and >=103.
5. Pulse rst 50 cycles into a conversion:
   - all outputs clear at once, no update pulse.
   - The next conversion produces correct values.
6. CHANNELS=1, DIGITS=4, SCALE=1, DATA_W=16, input 9876:
   - digits 9876, sat=0.
   - Input 10000 gives 9999 with sat=1.
   - Latency is 1*(34)+1 = 35 cycles.
